// File: rtl/metronome_arm_sequencer.sv
// Ping-pong sweep sequencer for an arm-animation ROM: steps the ROM address up and down at a
// programmable rate, pulses a beat at each endpoint and captures each new frame word.
module metronome_arm_sequencer #(
  parameter int unsigned DATA_WIDTH = 19,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned FRAMES     = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [23:0]           step_period,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  beat,
  output logic                  dir,
  output logic [7:0]            beat_count
);

  typedef enum logic [1:0] {StIdle, StSweepUp, StSweepDown} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FRAMES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    dir_q, dir_d;
  logic [23:0]             cnt_q, cnt_d;
  logic [1:0]              pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0]   frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    beat_q, beat_d;
  logic [7:0]              beats_q, beats_d;

  logic [23:0]             period_m1;
  logic [ADDR_WIDTH-1:0]   addr_inc, addr_dec;
  logic                    sweeping, step, hit_top, hit_bottom;

  // A period of zero behaves like a period of one: a step every cycle.
  assign period_m1  = (step_period == 24'd0) ? 24'd0 : step_period - 24'd1;
  assign sweeping   = (state_q != StIdle) && run;
  // >= rather than == so that shrinking step_period mid-count still yields a prompt step.
  assign step       = sweeping && (cnt_q >= period_m1);
  assign addr_inc   = addr_q + 1'b1;
  assign addr_dec   = addr_q - 1'b1;
  assign hit_top    = (state_q == StSweepUp) && (addr_inc == LastAddr);
  assign hit_bottom = (state_q == StSweepDown) && (addr_dec == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = dir_q ? StSweepUp : StSweepDown;
      end
      StSweepUp: begin
        if (!run) begin
          state_d = StIdle;
        end else if (step && hit_top) begin
          state_d = StSweepDown;
        end
      end
      StSweepDown: begin
        if (!run) begin
          state_d = StIdle;
        end else if (step && hit_bottom) begin
          state_d = StSweepUp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    beat_d  = 1'b0;
    beats_d = beats_q;
    if (sweeping) begin
      cnt_d = step ? 24'd0 : cnt_q + 24'd1;
    end
    if (step) begin
      if (state_q == StSweepUp) begin
        addr_d = addr_inc;
        if (hit_top) begin
          beat_d  = 1'b1;
          beats_d = beats_q + 8'd1;
          dir_d   = 1'b0;
        end
      end else begin
        addr_d = addr_dec;
        if (hit_bottom) begin
          beat_d  = 1'b1;
          beats_d = beats_q + 8'd1;
          dir_d   = 1'b1;
        end
      end
    end
    // Two stages cover the address register plus the ROM's own output register.
    pipe_d  = {pipe_q[0], step};
    valid_d = pipe_q[1];
    frame_d = pipe_q[1] ? rom_q : frame_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= 24'd0;
      pipe_q  <= 2'b00;
      frame_q <= '0;
      valid_q <= 1'b0;
      beat_q  <= 1'b0;
      beats_q <= 8'd0;
    end else begin
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      beats_q <= beats_d;
    end
  end

  assign rom_addr    = addr_q;
  assign dir         = dir_q;
  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign beat        = beat_q;
  assign beat_count  = beats_q;

endmodule

// File: tb/tb_metronome_arm_sequencer.sv
// Scoreboard bench: directed phases push hand-computed address/frame/beat expectations, a
// negedge monitor pops and compares them as the DUT presents changes and pulses.
module tb_metronome_arm_sequencer;

  localparam int unsigned DW = 19;
  localparam int unsigned AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_run, a_frame_valid, a_beat, a_dir;
  logic [23:0]   a_period;
  logic [AW-1:0] a_rom_addr;
  logic [DW-1:0] a_rom_q, a_frame_data;
  logic [7:0]    a_beat_count;

  logic          b_reset, b_run, b_frame_valid, b_beat, b_dir;
  logic [23:0]   b_period;
  logic [AW-1:0] b_rom_addr;
  logic [DW-1:0] b_rom_q, b_frame_data;
  logic [7:0]    b_beat_count;

  metronome_arm_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAMES(4)) dut_a (
    .clk(clk), .reset(a_reset), .run(a_run), .step_period(a_period), .rom_addr(a_rom_addr),
    .rom_q(a_rom_q), .frame_data(a_frame_data), .frame_valid(a_frame_valid), .beat(a_beat),
    .dir(a_dir), .beat_count(a_beat_count)
  );

  metronome_arm_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAMES(8)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run), .step_period(b_period), .rom_addr(b_rom_addr),
    .rom_q(b_rom_q), .frame_data(b_frame_data), .frame_valid(b_frame_valid), .beat(b_beat),
    .dir(b_dir), .beat_count(b_beat_count)
  );

  // Registered ROM models: q = addr + 0x100.
  always @(posedge clk) a_rom_q <= DW'(32'h100 + 32'(a_rom_addr));
  always @(posedge clk) b_rom_q <= DW'(32'h100 + 32'(b_rom_addr));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected no event at %0t", name, act, $time);
  endtask

  // Expected address changes (FRAMES=4): P=3 ping-pong, P=0 ping-pong, P=3 with freeze/blip.
  // Gap = cycles since the previous change; 0 means not checked (after an idle).
  int addr_tab[18] = '{1, 2, 3, 2, 1, 0,  1, 2, 3, 2, 1, 0,  1, 2, 3, 2, 1, 0};
  int gap_tab[18]  = '{0, 3, 3, 3, 3, 3,  1, 1, 1, 1, 1, 1,  3, 3, 0, 0, 3, 3};
  int baddr_tab[6] = '{3, 0, 3, 0, 3, 0};
  int bcnt_tab[6]  = '{1, 2, 3, 4, 5, 6};
  int bdir_tab[6]  = '{0, 1, 0, 1, 0, 1};

  int q_addr[$], q_gap[$], q_frame[$], q_baddr[$], q_bcnt[$], q_bdir[$];

  bit mon_en = 1'b0;
  int gap_cnt = 0, prev = 0, h1 = 0, h2 = 0, fv_count = 0;
  int ea, eg;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        gap_cnt++;
        if (int'(a_rom_addr) != prev) begin
          if (q_addr.size() == 0) begin
            miss("addr_unexpected", 32'(a_rom_addr));
          end else begin
            ea = q_addr.pop_front();
            eg = q_gap.pop_front();
            check("addr_seq", 32'(a_rom_addr), ea);
            if (eg != 0) check("addr_gap", gap_cnt, eg);
          end
          gap_cnt = 0;
          prev = int'(a_rom_addr);
        end
        if (a_beat) begin
          if (q_baddr.size() == 0) begin
            miss("beat_unexpected", 32'(a_rom_addr));
          end else begin
            check("beat_addr", 32'(a_rom_addr), q_baddr.pop_front());
            check("beat_count", 32'(a_beat_count), q_bcnt.pop_front());
            check("beat_dir", 32'(a_dir), q_bdir.pop_front());
          end
        end
        if (a_frame_valid) begin
          fv_count++;
          if (q_frame.size() == 0) begin
            miss("frame_unexpected", 32'(a_frame_data));
          end else begin
            check("frame_data", 32'(a_frame_data), q_frame.pop_front());
          end
          check("frame_latency", 32'(a_frame_data), 32'h100 + h2);
        end
      end
      h2 = h1;
      h1 = int'(a_rom_addr);
    end
  end

  int fv0, fvb;

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_run = 1'b0;   b_run = 1'b0;
    a_period = 24'd3; b_period = 24'd1;
    for (int i = 0; i < 18; i++) begin
      q_addr.push_back(addr_tab[i]);
      q_gap.push_back(gap_tab[i]);
      q_frame.push_back(32'h100 + addr_tab[i]);
    end
    for (int i = 0; i < 6; i++) begin
      q_baddr.push_back(baddr_tab[i]);
      q_bcnt.push_back(bcnt_tab[i]);
      q_bdir.push_back(bdir_tab[i]);
    end
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(a_rom_addr), 0);
    check("rst_dir", 32'(a_dir), 1);
    check("rst_beat_count", 32'(a_beat_count), 0);
    check("rst_frame_valid", 32'(a_frame_valid), 0);
    check("rst_beat", 32'(a_beat), 0);
    check("rst_frame_data", 32'(a_frame_data), 0);

    // Basic step and ping-pong with P=3.
    a_reset = 1'b0; b_reset = 1'b0; mon_en = 1'b1; a_run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (a_beat_count == 8'd2) break;
      @(negedge clk);
    end
    check("pp_beat_count", 32'(a_beat_count), 2);
    check("pp_dir", 32'(a_dir), 1);
    check("pp_addr", 32'(a_rom_addr), 0);

    // Zero period: one step per cycle.
    a_period = 24'd0;
    for (int i = 0; i < 50; i++) begin
      if (a_beat_count == 8'd4) break;
      @(negedge clk);
    end
    check("zero_beat_count", 32'(a_beat_count), 4);

    // Freeze while going up at address 2.
    a_period = 24'd3;
    for (int i = 0; i < 100; i++) begin
      if (a_rom_addr == 7'd2 && a_dir && a_beat_count == 8'd4) break;
      @(negedge clk);
    end
    check("freeze_at", 32'(a_rom_addr), 2);
    a_run = 1'b0;
    fv0 = fv_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("freeze_hold", 32'(a_rom_addr), 2);
    end
    check("freeze_frames", fv_count - fv0, 1);
    check("freeze_dir", 32'(a_dir), 1);
    a_run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (a_beat_count == 8'd5) break;
      @(negedge clk);
    end
    check("rerun_beat_count", 32'(a_beat_count), 5);

    // One-cycle run drop while going down.
    a_run = 1'b0;
    @(negedge clk);
    a_run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (a_beat_count == 8'd6) break;
      @(negedge clk);
    end
    a_run = 1'b0;
    check("blip_beat_count", 32'(a_beat_count), 6);
    check("blip_dir", 32'(a_dir), 1);
    check("blip_addr", 32'(a_rom_addr), 0);
    repeat (6) @(negedge clk);
    check("left_addr", q_addr.size(), 0);
    check("left_frame", q_frame.size(), 0);
    check("left_beat", q_baddr.size(), 0);
    mon_en = 1'b0;

    // Reset mid-sweep (FRAMES=8) while going down at address 5.
    b_run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b_rom_addr == 7'd5 && !b_dir) break;
      @(negedge clk);
    end
    check("b_at5", 32'(b_rom_addr), 5);
    check("b_pre_beat_count", 32'(b_beat_count), 1);
    b_reset = 1'b1;
    @(negedge clk);
    check("b_rst_addr", 32'(b_rom_addr), 0);
    check("b_rst_dir", 32'(b_dir), 1);
    check("b_rst_beat_count", 32'(b_beat_count), 0);
    check("b_rst_frame_valid", 32'(b_frame_valid), 0);
    check("b_rst_beat", 32'(b_beat), 0);
    b_reset = 1'b0;
    b_run = 1'b0;
    fvb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_frame_valid) fvb++;
    end
    check("b_no_frame_after_reset", fvb, 0);
    check("b_idle_addr", 32'(b_rom_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/metronome_arm_sequencer.md
METRONOME_ARM_SEQUENCER -- requirements
Module: metronome_arm_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 19, SHALL set the arm ROM word width.
REQ-002 Parameter ADDR_WIDTH, default 7, SHALL set the arm ROM address width.
REQ-003 Parameter FRAMES, default 128, SHALL set the number of sweep frames; legal range is 2..2**ADDR_WIDTH.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port run, input, 1 bit, SHALL enable sweeping when 1 and freeze it when 0.
REQ-007 Port step_period, input, 24 bits, SHALL give the clk cycles per frame step.
REQ-008 Port rom_addr, output, ADDR_WIDTH bits, SHALL drive the arm ROM address from a register.
REQ-009 Port rom_q, input, DATA_WIDTH bits, SHALL carry arm ROM data, registered in the ROM one cycle after the address.
REQ-010 Port frame_data, output, DATA_WIDTH bits, SHALL hold the last captured arm frame word.
REQ-011 Port frame_valid, output, 1 bit, SHALL pulse for one cycle when frame_data updates.
REQ-012 Port beat, output, 1 bit, SHALL pulse for one cycle at each sweep endpoint.
REQ-013 Port dir, output, 1 bit, SHALL be 1 for an up sweep and 0 for a down sweep.
REQ-014 Port beat_count, output, 8 bits, SHALL count beats and wrap from 255 to 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, SWEEP_UP and SWEEP_DOWN.
REQ-016 From IDLE the FSM SHALL enter SWEEP_UP when run=1 and dir=1, and SWEEP_DOWN when run=1 and dir=0.
REQ-017 The FSM SHALL return to IDLE from either sweep state in the cycle after run=0 is sampled; rom_addr, dir and the step counter SHALL hold in IDLE.
REQ-018 In a sweep state, a 24-bit step counter SHALL count 0..P-1, then raise a one-cycle step strobe and clear.
REQ-019 P SHALL equal step_period, except step_period=0 SHALL be treated as P=1.
REQ-020 step_period SHALL be sampled each cycle; a new value takes effect at the next counter comparison.
REQ-021 On a step strobe in SWEEP_UP, rom_addr SHALL increment.
REQ-022 If the incremented rom_addr equals FRAMES-1: beat SHALL pulse, beat_count SHALL increment, dir SHALL clear, and the FSM SHALL go to SWEEP_DOWN.
REQ-023 On a step strobe in SWEEP_DOWN, rom_addr SHALL decrement.
REQ-024 If the decremented rom_addr equals 0: beat SHALL pulse, beat_count SHALL increment, dir SHALL set, and the FSM SHALL go to SWEEP_UP.
REQ-025 rom_addr SHALL never leave 0..FRAMES-1; no address wrap SHALL occur.
REQ-026 beat SHALL assert in the cycle after the step strobe, coincident with the new rom_addr.
REQ-027 A two-stage delay of the step strobe SHALL align capture with ROM latency.
REQ-028 frame_data SHALL load rom_q and frame_valid SHALL assert two cycles after rom_addr changes.
REQ-029 A frame capture already in the delay pipe SHALL complete when run drops.
REQ-030 If run=0 and run=1 occur on consecutive cycles, the sweep SHALL resume from the held address and direction with the step counter at its held value.
REQ-031 Entering IDLE SHALL neither generate frame_valid nor beat.
REQ-032 Leaving IDLE SHALL neither generate frame_valid nor beat.

Reset
REQ-033 On reset=1, the FSM SHALL go to IDLE.
REQ-034 On reset=1, rom_addr, step counter, delay pipe, frame_data, frame_valid, beat and beat_count SHALL all be 0, and dir SHALL be 1.
REQ-035 Reset SHALL override run and abort any capture in flight: no frame_valid is produced after a reset edge.
REQ-036 Outputs SHALL reach their reset values one clock edge after reset is sampled high.

Verification
REQ-037 Basic step: FRAMES=4, P=3, run=1 from reset -> rom_addr steps 0,1,2,3 every 3 cycles; beat pulses with rom_addr=3; dir then goes to 0.
REQ-038 Ping-pong: continue REQ-037 -> rom_addr steps 2,1,0; beat pulses at 0; beat_count=2; dir=1.
REQ-039 Latency: ROM model with q=addr+0x100 -> every frame_valid pulse shows frame_data = 0x100 + rom_addr as it was 2 cycles earlier.
REQ-040 Zero period: step_period=0, FRAMES=4 -> rom_addr changes every cycle; sequence is 0,1,2,3,2,1,0.
REQ-041 Freeze: run=0 at rom_addr=2 going up -> rom_addr stays 2; exactly one pending frame_valid (if any); rerun continues to 3.
REQ-042 Reset mid-sweep: reset during SWEEP_DOWN at rom_addr=5 -> next cycle rom_addr=0, dir=1, beat_count=0; no frame_valid follows.
